// File: rtl/free_ptr_pool_pkg.sv
// Shared types and sizing helpers for the free pointer pool.
package free_ptr_pool_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } pool_state_e;

   // Bits needed to hold a count in the range 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/free_ptr_pool_rr_arbiter.sv
// Round-robin single-grant arbiter for the pointer-return ports.
// The search starts at the port after the last accepted one; the
// priority pointer only moves when a grant is actually issued.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] prio_q, prio_d;
   logic          found;

   // Pick the first requester at or after prio_q, wrapping around.
   always_comb begin
      grant  = '0;
      prio_d = prio_q;
      found  = 1'b0;
      for (int off = 0; off < N; off++) begin
         for (int i = 0; i < N; i++) begin
            if (en && !found && req[i] && (((int'(prio_q) + off) % N) == i)) begin
               found    = 1'b1;
               grant[i] = 1'b1;
               prio_d   = IW'((i + 1) % N);
            end
         end
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk) begin
      if (rstn) begin
         prio_q <= '0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/free_ptr_pool.sv
// Free pointer pool: circular buffer of pointers, self-filled with
// 0..DEPTH-1 after reset, first-word-fall-through allocation port and
// N_RET round-robin arbitrated return ports.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_INIT | writing pointer k at tail on the k-th cycle after reset
// ST_RUN  | normal allocate / return operation
module free_ptr_pool
   import free_ptr_pool_pkg::*;
#(
   parameter int PTR_W  = 10,
   parameter int DEPTH  = 512,
   parameter int N_RET  = 2,
   parameter int LOW_WM = 16
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        alloc_rd,
   output logic [PTR_W-1:0]            alloc_ptr,
   output logic                        alloc_valid,
   input  logic [N_RET-1:0]            ret_valid,
   input  logic [N_RET*PTR_W-1:0]      ret_ptr,
   output logic [N_RET-1:0]            ret_ready,
   output logic [cnt_width(DEPTH)-1:0] free_cnt,
   output logic                        init_done,
   output logic                        low_wm,
   output logic                        err_ovf,
   output logic                        err_udf,
   input  logic                        err_clr
);

   localparam int                CNT_W    = cnt_width(DEPTH);
   localparam int                IDX_W    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

   pool_state_e      state_q, state_d;
   logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [IDX_W-1:0] head_inc, tail_inc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             init_done_q, init_done_d;
   logic             low_wm_q, low_wm_d;
   logic             err_ovf_q, err_ovf_d;
   logic             err_udf_q, err_udf_d;

   logic [PTR_W-1:0] mem_q [DEPTH];
   logic             wr_en;
   logic [PTR_W-1:0] wr_data;

   logic [N_RET-1:0] grant;
   logic [PTR_W-1:0] ret_sel;
   logic             run, full, alloc_fire, ret_fire, ret_store;

   assign run        = (state_q == ST_RUN);
   assign full       = (cnt_q == FULL_CNT);
   assign head_inc   = (head_q == LAST_IDX) ? '0 : head_q + IDX_W'(1);
   assign tail_inc   = (tail_q == LAST_IDX) ? '0 : tail_q + IDX_W'(1);

   assign alloc_valid = run && (cnt_q != '0);
   assign alloc_ptr   = mem_q[head_q];
   assign alloc_fire  = alloc_rd && alloc_valid;
   assign ret_ready   = grant;
   assign ret_fire    = |(ret_valid & grant);
   // When full, a same-cycle allocation frees the slot the return lands in.
   assign ret_store   = ret_fire && (!full || alloc_fire);

   assign free_cnt  = cnt_q;
   assign init_done = init_done_q;
   assign low_wm    = low_wm_q;
   assign err_ovf   = err_ovf_q;
   assign err_udf   = err_udf_q;

   // Returns are only granted in RUN and never while reset is held.
   rr_arbiter #(.N(N_RET)) u_rr_arbiter (
      .clk   (clk),
      .rstn  (rstn),
      .en    (run && !rstn),
      .req   (ret_valid),
      .grant (grant)
   );

   // Pointer of the granted return port.
   always_comb begin
      ret_sel = '0;
      for (int i = 0; i < N_RET; i++) begin
         if (grant[i]) begin
            ret_sel = ret_ptr[i*PTR_W +: PTR_W];
         end
      end
   end

   // Next-state, pointer/count update and sticky error logic.
   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      tail_d      = tail_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      err_ovf_d   = err_ovf_q & ~err_clr;
      err_udf_d   = err_udf_q & ~err_clr;
      wr_en       = 1'b0;
      wr_data     = '0;
      unique case (state_q)
         ST_INIT: begin
            wr_en   = 1'b1;
            wr_data = PTR_W'(tail_q);
            tail_d  = tail_inc;
            cnt_d   = cnt_q + CNT_W'(1);
            if (tail_q == LAST_IDX) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (alloc_fire) begin
               head_d = head_inc;
            end
            if (alloc_rd && !alloc_valid) begin
               err_udf_d = 1'b1;
            end
            if (ret_store) begin
               wr_en   = 1'b1;
               wr_data = ret_sel;
               tail_d  = tail_inc;
            end else if (ret_fire) begin
               err_ovf_d = 1'b1;
            end
            unique case ({ret_store, alloc_fire})
               2'b10:   cnt_d = cnt_q + CNT_W'(1);
               2'b01:   cnt_d = cnt_q - CNT_W'(1);
               default: cnt_d = cnt_q;
            endcase
         end
         default: state_d = ST_INIT;
      endcase
      low_wm_d = (int'(cnt_d) < LOW_WM);
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q     <= ST_INIT;
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         low_wm_q    <= 1'b1;
         err_ovf_q   <= 1'b0;
         err_udf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         low_wm_q    <= low_wm_d;
         err_ovf_q   <= err_ovf_d;
         err_udf_q   <= err_udf_d;
      end
   end

   // Pointer storage; contents are rebuilt by INIT so it carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en && !rstn) begin
         mem_q[tail_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_free_ptr_pool.sv
// Testbench for free_ptr_pool: directed scenarios on the default
// configuration plus a long randomized run on a DEPTH=8, N_RET=3 pool
// checked against a queue-based model of the pool contents.
module tb_free_ptr_pool;

   localparam int A_PW = 10, A_DEPTH = 512, A_NR = 2, A_LWM = 16, A_CW = 10;
   localparam int B_PW = 3,  B_DEPTH = 8,   B_NR = 3, B_LWM = 3,  B_CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 a_rstn, a_alloc_rd, a_err_clr;
   logic [A_NR-1:0]      a_ret_valid, a_ret_ready;
   logic [A_NR*A_PW-1:0] a_ret_ptr;
   logic [A_PW-1:0]      a_alloc_ptr;
   logic                 a_alloc_valid, a_init_done, a_low_wm, a_err_ovf, a_err_udf;
   logic [A_CW-1:0]      a_free_cnt;

   logic                 b_rstn, b_alloc_rd, b_err_clr;
   logic [B_NR-1:0]      b_ret_valid, b_ret_ready;
   logic [B_NR*B_PW-1:0] b_ret_ptr;
   logic [B_PW-1:0]      b_alloc_ptr;
   logic                 b_alloc_valid, b_init_done, b_low_wm, b_err_ovf, b_err_udf;
   logic [B_CW-1:0]      b_free_cnt;

   free_ptr_pool dut_a (
      .clk(clk), .rstn(a_rstn), .alloc_rd(a_alloc_rd), .alloc_ptr(a_alloc_ptr),
      .alloc_valid(a_alloc_valid), .ret_valid(a_ret_valid), .ret_ptr(a_ret_ptr),
      .ret_ready(a_ret_ready), .free_cnt(a_free_cnt), .init_done(a_init_done),
      .low_wm(a_low_wm), .err_ovf(a_err_ovf), .err_udf(a_err_udf), .err_clr(a_err_clr)
   );

   free_ptr_pool #(.PTR_W(B_PW), .DEPTH(B_DEPTH), .N_RET(B_NR), .LOW_WM(B_LWM)) dut_b (
      .clk(clk), .rstn(b_rstn), .alloc_rd(b_alloc_rd), .alloc_ptr(b_alloc_ptr),
      .alloc_valid(b_alloc_valid), .ret_valid(b_ret_valid), .ret_ptr(b_ret_ptr),
      .ret_ready(b_ret_ready), .free_cnt(b_free_cnt), .init_done(b_init_done),
      .low_wm(b_low_wm), .err_ovf(b_err_ovf), .err_udf(b_err_udf), .err_clr(b_err_clr)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int aq[$];
   int a_rr;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected granted port: first valid port searching from 'start'.
   function automatic int rr_pick(input logic [2:0] v, input int start, input int n);
      for (int off = 0; off < n; off++) begin
         int p;
         p = (start + off) % n;
         if (((v >> p) & 3'd1) != 3'd0) return p;
      end
      return -1;
   endfunction

   task automatic a_idle;
      a_alloc_rd  = 1'b0;
      a_err_clr   = 1'b0;
      a_ret_valid = '0;
      a_ret_ptr   = '0;
   endtask

   task automatic a_reset_init;
      a_idle();
      a_rstn = 1'b1;
      tick();
      tick();
      a_rstn = 1'b0;
      repeat (A_DEPTH + 1) tick();
      aq.delete();
      for (int i = 0; i < A_DEPTH; i++) aq.push_back(i);
      a_rr = 0;
   endtask

   task automatic test_reset_init;
      a_rstn      = 1'b1;
      a_alloc_rd  = 1'b1;
      a_err_clr   = 1'b0;
      a_ret_valid = 2'b11;
      a_ret_ptr   = '0;
      tick();
      tick();
      n_tests++; if (a_free_cnt !== 10'd0) begin n_fail++; $display("FAIL reset_free_cnt got %0d want 0", a_free_cnt); end
      n_tests++; if (a_init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got %b want 0", a_init_done); end
      n_tests++; if (a_low_wm !== 1'b1) begin n_fail++; $display("FAIL reset_low_wm got %b want 1", a_low_wm); end
      n_tests++; if (a_alloc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alloc_valid got %b want 0", a_alloc_valid); end
      n_tests++; if ({a_err_ovf, a_err_udf} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b want 00", {a_err_ovf, a_err_udf}); end
      n_tests++; if (a_ret_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ret_ready got %b want 00", a_ret_ready); end
      a_rstn = 1'b0;
      #1;
      n_tests++; if (a_ret_ready !== 2'b00) begin n_fail++; $display("FAIL post_reset_ret_ready got %b want 00", a_ret_ready); end
      for (int i = 1; i <= A_DEPTH + 1; i++) begin
         tick();
         if (i == A_DEPTH - 1) begin
            n_tests++; if (a_init_done !== 1'b0) begin n_fail++; $display("FAIL init_early_done got %b want 0", a_init_done); end
            n_tests++; if (a_free_cnt !== 10'(A_DEPTH - 1)) begin n_fail++; $display("FAIL init_cnt got %0d want %0d", a_free_cnt, A_DEPTH - 1); end
            n_tests++; if ({a_ret_ready, a_alloc_valid} !== 3'b000) begin n_fail++; $display("FAIL init_handshake got %b want 000", {a_ret_ready, a_alloc_valid}); end
            a_idle();
         end
      end
      n_tests++; if (a_init_done !== 1'b1) begin n_fail++; $display("FAIL init_done got %b want 1", a_init_done); end
      n_tests++; if (a_free_cnt !== 10'(A_DEPTH)) begin n_fail++; $display("FAIL init_full_cnt got %0d want %0d", a_free_cnt, A_DEPTH); end
      n_tests++; if (a_alloc_valid !== 1'b1 || a_alloc_ptr !== 10'd0) begin n_fail++; $display("FAIL init_head got v=%b p=%0d want v=1 p=0", a_alloc_valid, a_alloc_ptr); end
      n_tests++; if (a_low_wm !== 1'b0) begin n_fail++; $display("FAIL init_low_wm got %b want 0", a_low_wm); end
      n_tests++; if (a_err_udf !== 1'b0) begin n_fail++; $display("FAIL init_udf_ignored got %b want 0", a_err_udf); end
      aq.delete();
      for (int i = 0; i < A_DEPTH; i++) aq.push_back(i);
      a_rr = 0;
   endtask

   task automatic test_drain;
      for (int i = 0; i < A_DEPTH; i++) begin
         a_alloc_rd = 1'b1;
         #1;
         n_tests++; if (a_alloc_valid !== 1'b1 || a_alloc_ptr !== 10'(aq[0])) begin n_fail++; $display("FAIL drain_ptr got v=%b p=%0d want v=1 p=%0d", a_alloc_valid, a_alloc_ptr, aq[0]); end
         n_tests++; if (a_free_cnt !== 10'(aq.size()) || a_low_wm !== (aq.size() < A_LWM)) begin n_fail++; $display("FAIL drain_cnt got %0d/%b want %0d", a_free_cnt, a_low_wm, aq.size()); end
         tick();
         void'(aq.pop_front());
      end
      a_alloc_rd = 1'b0;
      #1;
      n_tests++; if (a_alloc_valid !== 1'b0 || a_low_wm !== 1'b1 || a_free_cnt !== 10'd0) begin n_fail++; $display("FAIL drain_empty got v=%b lw=%b cnt=%0d want 0 1 0", a_alloc_valid, a_low_wm, a_free_cnt); end
   endtask

   task automatic test_empty_return;
      a_ret_valid = 2'b01;
      a_ret_ptr   = {10'd0, 10'h05A};
      a_alloc_rd  = 1'b1;
      #1;
      n_tests++; if (a_ret_ready !== 2'b01 || a_alloc_valid !== 1'b0) begin n_fail++; $display("FAIL empty_ret got rdy=%b v=%b want 01 0", a_ret_ready, a_alloc_valid); end
      tick();
      aq.push_back('h05A);
      a_rr = 1;
      a_idle();
      #1;
      n_tests++; if (a_alloc_valid !== 1'b1 || a_alloc_ptr !== 10'h05A) begin n_fail++; $display("FAIL empty_ret_avail got v=%b p=%h want 1 05a", a_alloc_valid, a_alloc_ptr); end
      n_tests++; if (a_err_udf !== 1'b1 || a_free_cnt !== 10'd1) begin n_fail++; $display("FAIL udf_set got udf=%b cnt=%0d want 1 1", a_err_udf, a_free_cnt); end
      a_alloc_rd = 1'b1;
      tick();
      void'(aq.pop_front());
      a_err_clr = 1'b1;
      tick();
      n_tests++; if (a_err_udf !== 1'b1) begin n_fail++; $display("FAIL udf_clr_priority got %b want 1", a_err_udf); end
      a_alloc_rd = 1'b0;
      tick();
      n_tests++; if (a_err_udf !== 1'b0) begin n_fail++; $display("FAIL udf_clr got %b want 0", a_err_udf); end
      a_idle();
   endtask

   task automatic test_round_robin;
      int p, g;
      int base;
      logic [A_PW-1:0] vals [A_NR];
      base = aq.size();
      p = $urandom_range(0, A_DEPTH - 1);
      a_ret_valid = 2'b10;
      a_ret_ptr   = {10'(p), 10'd0};
      #1;
      g = rr_pick({1'b0, a_ret_valid}, a_rr, A_NR);
      n_tests++; if (a_ret_ready !== 2'(1 << g)) begin n_fail++; $display("FAIL rr_single got %b want %b", a_ret_ready, 2'(1 << g)); end
      tick();
      aq.push_back(p);
      a_rr = (g + 1) % A_NR;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < A_NR; i++) begin
            vals[i] = 10'($urandom_range(0, A_DEPTH - 1));
            a_ret_ptr[i*A_PW +: A_PW] = vals[i];
         end
         a_ret_valid = 2'b11;
         #1;
         g = rr_pick(3'b011, a_rr, A_NR);
         n_tests++; if (a_ret_ready !== 2'(1 << g) || g != (c % 2)) begin n_fail++; $display("FAIL rr_alternate cycle %0d got %b want %b", c, a_ret_ready, 2'(1 << (c % 2))); end
         tick();
         aq.push_back(int'(vals[g]));
         a_rr = (g + 1) % A_NR;
      end
      a_idle();
      #1;
      n_tests++; if (a_free_cnt !== 10'(base + 5)) begin n_fail++; $display("FAIL rr_cnt got %0d want %0d", a_free_cnt, base + 5); end
      while (aq.size() > 0) begin
         a_alloc_rd = 1'b1;
         #1;
         n_tests++; if (a_alloc_ptr !== 10'(aq[0])) begin n_fail++; $display("FAIL rr_order got %0d want %0d", a_alloc_ptr, aq[0]); end
         tick();
         void'(aq.pop_front());
      end
      a_idle();
   endtask

   task automatic test_overflow;
      int p;
      a_reset_init();
      a_ret_valid = 2'b10;
      a_ret_ptr   = {10'h1FF, 10'd0};
      #1;
      n_tests++; if (a_ret_ready !== 2'b10) begin n_fail++; $display("FAIL ovf_grant got %b want 10", a_ret_ready); end
      tick();
      a_rr = 0;
      a_idle();
      #1;
      n_tests++; if (a_err_ovf !== 1'b1 || a_free_cnt !== 10'(A_DEPTH)) begin n_fail++; $display("FAIL ovf_drop got ovf=%b cnt=%0d want 1 %0d", a_err_ovf, a_free_cnt, A_DEPTH); end
      n_tests++; if (a_alloc_ptr !== 10'd0) begin n_fail++; $display("FAIL ovf_head got %0d want 0", a_alloc_ptr); end
      a_err_clr = 1'b1;
      tick();
      a_err_clr = 1'b0;
      n_tests++; if (a_err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", a_err_ovf); end
      p = $urandom_range(0, A_DEPTH - 1);
      a_ret_valid = 2'b01;
      a_ret_ptr   = {10'd0, 10'(p)};
      a_alloc_rd  = 1'b1;
      #1;
      n_tests++; if (a_ret_ready !== 2'b01 || a_alloc_ptr !== 10'(aq[0])) begin n_fail++; $display("FAIL full_swap got rdy=%b p=%0d want 01 %0d", a_ret_ready, a_alloc_ptr, aq[0]); end
      tick();
      void'(aq.pop_front());
      aq.push_back(p);
      a_rr = 1;
      a_idle();
      #1;
      n_tests++; if (a_free_cnt !== 10'(A_DEPTH) || a_err_ovf !== 1'b0) begin n_fail++; $display("FAIL full_swap_cnt got cnt=%0d ovf=%b want %0d 0", a_free_cnt, a_err_ovf, A_DEPTH); end
      a_ret_valid = 2'b10;
      a_ret_ptr   = {10'($urandom_range(0, A_DEPTH - 1)), 10'd0};
      a_err_clr   = 1'b1;
      tick();
      a_rr = 0;
      a_ret_valid = 2'b00;
      n_tests++; if (a_err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_priority got %b want 1", a_err_ovf); end
      tick();
      a_idle();
      n_tests++; if (a_err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr2 got %b want 0", a_err_ovf); end
      while (aq.size() > 0) begin
         a_alloc_rd = 1'b1;
         #1;
         n_tests++; if (a_alloc_ptr !== 10'(aq[0])) begin n_fail++; $display("FAIL ovf_order got %0d want %0d", a_alloc_ptr, aq[0]); end
         tick();
         void'(aq.pop_front());
      end
      a_idle();
   endtask

   task automatic test_mid_reset;
      a_reset_init();
      a_alloc_rd = 1'b1;
      repeat (A_DEPTH - 100) tick();
      a_alloc_rd = 1'b0;
      #1;
      n_tests++; if (a_free_cnt !== 10'd100) begin n_fail++; $display("FAIL mid_cnt got %0d want 100", a_free_cnt); end
      a_rstn = 1'b1;
      tick();
      n_tests++; if (a_free_cnt !== 10'd0 || a_init_done !== 1'b0 || a_alloc_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset got cnt=%0d done=%b v=%b want 0 0 0", a_free_cnt, a_init_done, a_alloc_valid); end
      a_rstn = 1'b0;
      repeat (3) tick();
      n_tests++; if (a_free_cnt !== 10'd3 || a_init_done !== 1'b0) begin n_fail++; $display("FAIL refill_cnt got %0d/%b want 3/0", a_free_cnt, a_init_done); end
      repeat (A_DEPTH - 2) tick();
      n_tests++; if (a_init_done !== 1'b1 || a_free_cnt !== 10'(A_DEPTH)) begin n_fail++; $display("FAIL refill_done got %b/%0d want 1/%0d", a_init_done, a_free_cnt, A_DEPTH); end
      for (int k = 0; k < 4; k++) begin
         a_alloc_rd = 1'b1;
         #1;
         n_tests++; if (a_alloc_ptr !== 10'(k)) begin n_fail++; $display("FAIL refill_order got %0d want %0d", a_alloc_ptr, k); end
         tick();
      end
      a_idle();
   endtask

   task automatic test_random_small;
      int bq[$];
      int bout[$];
      int b_rr, g, popped;
      logic b_udf, ev;
      int cand [B_NR];
      int ci [B_NR];
      logic [B_DEPTH-1:0] seen;

      b_alloc_rd = 1'b0; b_err_clr = 1'b0; b_ret_valid = '0; b_ret_ptr = '0;
      b_rstn = 1'b1;
      tick();
      tick();
      b_rstn = 1'b0;
      repeat (B_DEPTH + 1) tick();
      n_tests++; if (b_init_done !== 1'b1 || b_free_cnt !== 4'(B_DEPTH)) begin n_fail++; $display("FAIL b_init got %b/%0d want 1/%0d", b_init_done, b_free_cnt, B_DEPTH); end
      for (int i = 0; i < B_DEPTH; i++) bq.push_back(i);
      b_rr  = 0;
      b_udf = 1'b0;

      for (int c = 0; c < 10000; c++) begin
         b_alloc_rd = 1'($urandom_range(0, 1));
         b_err_clr  = ($urandom_range(0, 15) == 0);
         b_ret_valid = '0;
         for (int p = 0; p < B_NR; p++) begin
            cand[p] = 0;
            ci[p]   = 0;
            if (bout.size() > 0 && $urandom_range(0, 1) == 1) begin
               ci[p]   = $urandom_range(0, bout.size() - 1);
               cand[p] = bout[ci[p]];
               b_ret_valid[p] = 1'b1;
            end
            b_ret_ptr[p*B_PW +: B_PW] = 3'(cand[p]);
         end
         #1;
         ev = (bq.size() > 0);
         g  = rr_pick(b_ret_valid, b_rr, B_NR);
         n_tests++; if (b_alloc_valid !== ev || (ev && b_alloc_ptr !== 3'(bq[0]))) begin n_fail++; $display("FAIL rnd_alloc cyc %0d got v=%b p=%0d want v=%b p=%0d", c, b_alloc_valid, b_alloc_ptr, ev, ev ? bq[0] : 0); end
         n_tests++; if (b_ret_ready !== ((g >= 0) ? 3'(1 << g) : 3'b000)) begin n_fail++; $display("FAIL rnd_grant cyc %0d got %b want grant %0d", c, b_ret_ready, g); end
         n_tests++; if (b_free_cnt !== 4'(bq.size()) || b_low_wm !== (bq.size() < B_LWM)) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got %0d/%b want %0d", c, b_free_cnt, b_low_wm, bq.size()); end
         n_tests++; if (b_err_udf !== b_udf || b_err_ovf !== 1'b0) begin n_fail++; $display("FAIL rnd_err cyc %0d got udf=%b ovf=%b want %b 0", c, b_err_udf, b_err_ovf, b_udf); end
         tick();
         popped = -1;
         if (b_alloc_rd && ev) popped = bq.pop_front();
         b_udf = (b_udf && !b_err_clr) || (b_alloc_rd && !ev);
         if (g >= 0) begin
            bq.push_back(cand[g]);
            bout.delete(ci[g]);
            b_rr = (g + 1) % B_NR;
         end
         if (popped >= 0) bout.push_back(popped);
      end

      b_alloc_rd = 1'b0;
      b_err_clr  = 1'b0;
      while (bout.size() > 0) begin
         b_ret_valid = 3'b001;
         b_ret_ptr   = {6'd0, 3'(bout[0])};
         tick();
         void'(bout.pop_front());
      end
      b_ret_valid = '0;
      #1;
      n_tests++; if (b_free_cnt !== 4'(B_DEPTH)) begin n_fail++; $display("FAIL rnd_refill got %0d want %0d", b_free_cnt, B_DEPTH); end
      seen = '0;
      for (int i = 0; i < B_DEPTH; i++) begin
         b_alloc_rd = 1'b1;
         #1;
         seen[b_alloc_ptr] = 1'b1;
         tick();
      end
      b_alloc_rd = 1'b0;
      n_tests++; if (seen !== 8'hFF) begin n_fail++; $display("FAIL rnd_unique got %b want 11111111", seen); end
   endtask

   initial begin
      a_rstn = 1'b1;
      a_idle();
      b_rstn = 1'b1;
      b_alloc_rd = 1'b0; b_err_clr = 1'b0; b_ret_valid = '0; b_ret_ptr = '0;
      test_reset_init();
      test_drain();
      test_empty_return();
      test_round_robin();
      test_overflow();
      test_mid_reset();
      test_random_small();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
